// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one-outstanding valid/ready fetch to a variable-latency
// instruction memory, feeding a DEPTH-entry prefetch FIFO of {pc, instruction} pairs.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] redirect_addr;
    logic            discard;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic            push;
    logic            pop;
    logic            space;

    always_comb begin
        redirect_addr = redirect_pc & ~XLEN'(3);
        pop           = (count != '0) && inst_ready;
        // A redirect kills the response arriving in the same cycle.
        push          = (state == S_WAIT) && imem_rsp_valid && !discard && !redirect_valid;
        count_next    = count;
        if (redirect_valid) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
        space = (count_next < FULL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_VEC;
            req_addr <= RESET_VEC;
            discard  <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            count <= count_next;
            if (redirect_valid) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= redirect_addr;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        state    <= S_REQ;
                        req_addr <= redirect_addr;
                    end else if (space) begin
                        state    <= S_REQ;
                        req_addr <= fetch_pc;
                    end
                end
                S_REQ: begin
                    // The presented request is never changed; a redirect only marks it stale.
                    if (redirect_valid) discard <= 1'b1;
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                        // A stale request must not advance the already-redirected fetch_pc.
                        if (!redirect_valid && !discard) fetch_pc <= fetch_pc + XLEN'(4);
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        discard <= 1'b0;
                        if (redirect_valid) begin
                            state    <= S_REQ;
                            req_addr <= redirect_addr;
                        end else if (space) begin
                            state    <= S_REQ;
                            req_addr <= fetch_pc;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = req_addr;
    assign inst_valid     = (count != '0);
    assign inst           = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc        = inst_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32I cores.
- Replaces the combinational PC register plus instruction-ROM path with a valid/ready request/response interface to a variable-latency instruction memory.
- Holds fetched instructions in a DEPTH-entry prefetch FIFO with their PCs.
- Accepts redirects (branch/jump) that flush the FIFO and discard in-flight fetches.
- The decode/execute stage consumes instructions through a valid/ready port.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_VEC, 32'h0000_0000, PC of the first fetch after reset (XLEN bits, low 2 bits zero)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  load new fetch PC and flush this cycle
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request present
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  response data valid; memory latency >= 1 cycle, in-order, one outstanding
imem_rsp_data  in  XLEN  fetched instruction
inst_valid  out  1  FIFO head valid
inst_ready  in  1  consumer takes head this cycle
inst  out  XLEN  head instruction
inst_pc  out  XLEN  PC of head instruction

Behaviour:
- Reset: The reset is synchronous and active-high. On reset, state=IDLE, fetch_pc=RESET_VEC, FIFO count=0, discard=0, req_addr=RESET_VEC. Outputs during and after reset: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0 (empty head reads 0). The instruction memory shares rst, so no response is pending after reset.
- FSM states:
  - IDLE: no request.
  - REQ: imem_req_valid=1, imem_req_addr=req_addr.
  - WAIT: one request accepted, response pending.
- IDLE -> REQ when count_next < DEPTH. On entering REQ, req_addr <= fetch_pc (or redirect_pc if a redirect occurs in the same cycle).
- REQ -> WAIT on imem_req_ready. fetch_pc <= fetch_pc + 4, modulo 2^XLEN, wraps to 0. req_addr stays stable while in REQ; redirect never alters a presented request.
- WAIT: imem_rsp_valid is sampled only in WAIT; it is ignored in IDLE and REQ.
  - If discard=0, push {req_addr, imem_rsp_data}.
  - If discard=1, drop the response and clear discard.
  - Next state is REQ if count_next < DEPTH, else IDLE.
- Redirect, any state: fetch_pc <= redirect_pc & ~3. FIFO count <= 0, overriding same-cycle push and pop. Per state:
  - IDLE: go to REQ next cycle with req_addr = redirect_pc.
  - REQ, with or without ready: set discard=1. The held request still completes and its response is dropped.
  - WAIT without rsp_valid: set discard=1.
  - WAIT with rsp_valid: drop the response, discard stays 0, go to REQ with the new PC.
- After redirect, the first instruction of the new stream has inst_pc = redirect_pc & ~3.
- FIFO:
  - inst_valid = (count != 0). Head is registered storage.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is issued only when space exists and one is outstanding at most.
  - Pointers wrap modulo DEPTH.
- Latency and throughput: with 1-cycle memory and ready always high, accept at cycle t, rsp at t+1, inst_valid at t+2. Throughput is 1 instruction per 2 cycles.
- Backpressure: with inst_ready=0, fetching stops after DEPTH entries (IDLE). It resumes the cycle after the first pop.
- Reset asserted mid-operation (any state, any count): returns to the reset condition next cycle. FIFO contents and discard are lost.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1, mem[0..3]=A0..A3 -> imem_req_valid first high 1 cycle after release with addr 0. Output stream is (0,A0),(4,A1),(8,A2),(C,A3), one every 2 cycles.
- inst_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests (0,4,8,C), then imem_req_valid=0. inst_pc=0 held. After one pop, next request has addr 0x10.
- Redirect to 0x103 while in WAIT (3-cycle memory) -> stale response for the old PC is dropped. Next request addr 0x100. First output inst_pc=0x100. inst_valid=0 the cycle after redirect.
- imem_req_ready=0 for 5 cycles with redirect to 0x200 during cycle 2 -> req_addr stays at the old value until accepted, and that response is discarded. Next request is 0x200.
- Redirect in the same cycle as rsp_valid and a pop with count=2 -> count=0 next cycle, nothing pushed. Next request is the redirect PC, no extra discard.
- XLEN=32, redirect to 0xFFFF_FFFC -> outputs (0xFFFF_FFFC, d0) then (0x0000_0000, d1). Assert rst in WAIT -> all outputs 0 next cycle, then fetch restarts at RESET_VEC.
